wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Two-requester Wishbone B4 arbiter: round-robin tie-break, bus lock while CYC is held.
// Define WB_ARB_WATCHDOG_EN to compile in the stalled-slave watchdog.
module wb_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_adr,
    input  logic [31:0] m0_dat_o,
    input  logic        m0_we,
    input  logic        m0_cyc,
    input  logic        m0_stb,
    output logic [31:0] m0_dat_i,
    output logic        m0_ack,
    input  logic [31:0] m1_adr,
    input  logic [31:0] m1_dat_o,
    input  logic        m1_we,
    input  logic        m1_cyc,
    input  logic        m1_stb,
    output logic [31:0] m1_dat_i,
    output logic        m1_ack,
    output logic [31:0] s_adr,
    output logic [31:0] s_dat_o,
    output logic        s_we,
    output logic        s_cyc,
    output logic        s_stb,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack,
    output logic [1:0]  grant,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_last_owner;
    logic   w_last_nxt;
    logic   w_timeout;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_arbiter: TIMEOUT_CYCLES must be within 1..65535");
    end

    // last_owner resets to 1 so m0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_last_owner <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_last_owner <= w_last_nxt;
        end
    end

    assign grant = r_state;

`ifdef WB_ARB_WATCHDOG_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] r_wdog_cnt;
    logic        r_bus_err;
    logic        w_own_stb;

    assign w_own_stb = ((r_state == ST_OWN0) && m0_cyc && m0_stb) ||
                       ((r_state == ST_OWN1) && m1_cyc && m1_stb);
    assign w_timeout = w_own_stb && (r_wdog_cnt == TIMEOUT_LIMIT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wdog_cnt <= '0;
            r_bus_err  <= 1'b0;
        end else begin
            if (r_state == ST_IDLE || s_ack || w_timeout)
                r_wdog_cnt <= '0;
            else if (w_own_stb)
                r_wdog_cnt <= r_wdog_cnt + 16'd1;
            if (w_timeout)
                r_bus_err <= 1'b1;
        end
    end

    assign bus_err = r_bus_err;
`else
    assign w_timeout = 1'b0;
    assign bus_err   = 1'b0;
`endif

    // Owner's request goes straight through; a watchdog hit fakes the ACK and withdraws STB.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last_owner;
        s_adr       = '0;
        s_dat_o     = '0;
        s_we        = 1'b0;
        s_cyc       = 1'b0;
        s_stb       = 1'b0;
        m0_ack      = 1'b0;
        m0_dat_i    = '0;
        m1_ack      = 1'b0;
        m1_dat_i    = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (m0_cyc && (!m1_cyc || r_last_owner))
                    w_state_nxt = ST_OWN0;
                else if (m1_cyc)
                    w_state_nxt = ST_OWN1;
            end
            ST_OWN0: begin
                s_adr    = m0_adr;
                s_dat_o  = m0_dat_o;
                s_we     = m0_we;
                s_cyc    = m0_cyc;
                s_stb    = m0_stb && !w_timeout;
                m0_ack   = s_ack || w_timeout;
                m0_dat_i = w_timeout ? ERR_DATA : s_dat_i;
                if (!m0_cyc) begin
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = 1'b0;
                end
            end
            ST_OWN1: begin
                s_adr    = m1_adr;
                s_dat_o  = m1_dat_o;
                s_we     = m1_we;
                s_cyc    = m1_cyc;
                s_stb    = m1_stb && !w_timeout;
                m1_ack   = s_ack || w_timeout;
                m1_dat_i = w_timeout ? ERR_DATA : s_dat_i;
                if (!m1_cyc) begin
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule
